// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style 8-bit LCD bus receiver: decodes EN falling-edge writes into
// char/command events and keeps a 2x16 shadow frame with a registered read port.
module lcd_bus_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    output logic       char_valid,
    output logic [4:0] char_pos,
    output logic [7:0] char_code,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       display_on,
    output logic       busy,
    output logic       err_overrun,
    output logic       err_addr,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char
);

    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic {S_IDLE, S_FILL} state_t;
    typedef enum logic [2:0] {C_NONE, C_CLEAR, C_HOME, C_ENTRY, C_DISP, C_DDRAM} cmd_t;

    logic [1:0] en_sync;
    logic       en_d;
    logic [1:0] rs_sync;
    logic [1:0] rw_sync;
    logic [7:0] data_s1;
    logic [7:0] data_s2;

    state_t     state, next_state;
    logic [4:0] fill_idx, next_fill_idx;
    cmd_t       cmd_kind;

    logic [6:0] addr;
    logic       inc;
    logic [4:0] cur_idx;
    logic       xfer_wr;
    logic       data_wr;
    logic       cmd_wr;
    logic       ddram_ok;

    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;
    logic [7:0] shadow [32];

    // All bus pins share one 2-flop chain; en gets a third flop for the falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_sync <= 2'b00;
            en_d    <= 1'b0;
            rs_sync <= 2'b00;
            rw_sync <= 2'b00;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value.
            en_sync <= {en_sync[0], lcd_en};
            en_d    <= en_sync[1];
            rs_sync <= {rs_sync[0], lcd_rs};
            rw_sync <= {rw_sync[0], lcd_rw};
            data_s1 <= lcd_data;
            data_s2 <= data_s1;
        end
    end

    assign xfer_wr  = en_d & ~en_sync[1] & ~rw_sync[1];
    assign data_wr  = xfer_wr & (state == S_IDLE) & rs_sync[1];
    assign cmd_wr   = xfer_wr & (state == S_IDLE) & ~rs_sync[1];
    assign cur_idx  = {addr[6], addr[3:0]};
    assign ddram_ok = (data_s2[5:4] == 2'b00);

    always_comb begin
        // NOTE: default first so every path assigns cmd_kind and no latch is inferred.
        cmd_kind = C_NONE;
        casez (data_s2)
            8'b1???_????: cmd_kind = C_DDRAM;
            8'b0000_1???: cmd_kind = C_DISP;
            8'b0000_01??: cmd_kind = C_ENTRY;
            8'b0000_001?: cmd_kind = C_HOME;
            8'b0000_0001: cmd_kind = C_CLEAR;
            default:      cmd_kind = C_NONE;
        endcase
    end

    // Cursor step with line wrap: 0x0F<->0x40 and 0x4F<->0x00.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        if (up)
            step_addr = (a[3:0] == 4'hF) ? {~a[6], 6'h00} : a + 7'd1;
        else
            step_addr = (a[3:0] == 4'h0) ? {~a[6], 6'h0F} : a - 7'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FILL;
            fill_idx <= 5'd0;
            busy     <= 1'b0;
        end else begin
            state    <= next_state;
            fill_idx <= next_fill_idx;
            busy     <= (next_state == S_FILL);
        end
    end

    always_comb begin
        next_state    = state;
        next_fill_idx = fill_idx;
        wr_en         = 1'b0;
        wr_idx        = cur_idx;
        wr_data       = data_s2;
        case (state)
            S_IDLE: begin
                if (cmd_wr && cmd_kind == C_CLEAR) begin
                    next_state    = S_FILL;
                    next_fill_idx = 5'd0;
                end else if (data_wr) begin
                    wr_en = 1'b1;
                end
            end
            S_FILL: begin
                wr_en         = 1'b1;
                wr_idx        = fill_idx;
                wr_data       = BLANK;
                next_fill_idx = fill_idx + 5'd1;
                if (fill_idx == 5'd31)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= 7'h00;
            inc         <= 1'b1;
            display_on  <= 1'b0;
            err_overrun <= 1'b0;
            err_addr    <= 1'b0;
            char_valid  <= 1'b0;
            char_pos    <= 5'd0;
            char_code   <= 8'h00;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'h00;
        end else begin
            char_valid <= data_wr;
            cmd_valid  <= cmd_wr;
            if (xfer_wr && state == S_FILL)
                err_overrun <= 1'b1;
            if (data_wr) begin
                char_pos  <= cur_idx;
                char_code <= data_s2;
                addr      <= step_addr(addr, inc);
            end
            if (cmd_wr) begin
                cmd_code <= data_s2;
                case (cmd_kind)
                    C_CLEAR: begin
                        addr <= 7'h00;
                        inc  <= 1'b1;
                    end
                    C_HOME:  addr <= 7'h00;
                    C_ENTRY: inc <= data_s2[1];
                    C_DISP:  display_on <= data_s2[2];
                    C_DDRAM: begin
                        if (ddram_ok) begin
                            addr <= data_s2[6:0];
                        end else begin
                            err_addr <= 1'b1;
                            addr     <= 7'h00;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the shadow array has no reset; the FILL pass after reset initialises it.
    always_ff @(posedge clk) begin
        if (wr_en)
            shadow[wr_idx] <= wr_data;
    end

    // Write-first: a write landing on the read index this cycle is forwarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_char <= 8'h00;
        else
            rd_char <= (wr_en && wr_idx == rd_idx) ? wr_data : shadow[rd_idx];
    end

endmodule
